// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_SW        = 16;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOST_BURST = 2'd1,
    CPU_FORCE  = 2'd2
  } arb_state_e;

  // Width of a counter that must hold the values 0..max_burst.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store path and a host
// preload/readback port. Host has priority, limited by a burst cap while the
// CPU is waiting; the CPU is stalled on lost cycles and stalls are counted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int SW        = DEF_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // Host side
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  // Memory side
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // Statistics
  output logic [SW-1:0] stall_cnt
);

  localparam int             BCW       = burst_cnt_width(MAX_BURST);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);

  arb_state_e     state_q;
  logic [BCW-1:0] burst_cnt_q;
  logic [BCW-1:0] burst_cnt_d;
  logic           host_rvalid_q;
  logic [DW-1:0]  host_rdata_q;
  logic [SW-1:0]  stall_cnt_q;

  logic host_served;
  logic cpu_served;

  // Grant decision: host first unless the CPU has been forced in after a full burst.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    host_served = 1'b0;
    cpu_served  = 1'b0;
    if (state_q == CPU_FORCE) begin
      cpu_served  = cpu_req;
      host_served = host_req & ~cpu_req;
    end else begin
      host_served = host_req;
      cpu_served  = cpu_req & ~host_req;
    end
  end

  // Burst length after a host grant this cycle; a fresh run starts at 1 and
  // the count saturates at the cap.
  always_comb begin
    if (state_q != HOST_BURST) begin
      burst_cnt_d = BCW'(1);
    end else if (burst_cnt_q == BURST_MAX) begin
      burst_cnt_d = BURST_MAX;
    end else begin
      burst_cnt_d = burst_cnt_q + BCW'(1);
    end
  end

  // Memory mux: the served requester drives the port; writes are blocked in reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (host_served) begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end else if (cpu_served) begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // Ownership FSM: track host run length and force a CPU slot once the run
  // reaches the cap with the CPU waiting (MAX_BURST=1 therefore alternates).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else if (host_served) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      burst_cnt_q <= burst_cnt_d;
      state_q     <= (burst_cnt_d == BURST_MAX && cpu_req) ? CPU_FORCE : HOST_BURST;
    end else begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end
  end

  // Host read return: capture memory data one cycle after a granted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid_q <= 1'b0;
      // NOTE: host_rdata is a single output register, not a memory array, so
      // it is cheap to reset and gives a defined value before the first read.
      host_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= host_served & ~host_we;
      if (host_served && !host_we) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  // Saturating count of CPU stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (cpu_stall && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + SW'(1);
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_served;
  assign cpu_rdata   = mem_rdata;
  assign host_gnt    = host_served;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
